uart_phase_cmd_parser: RTL and testbench
========================================

# uart_phase_cmd_parser

Parametrised receiver-side command parser. It converts the ASCII byte stream from the UART receiver into validated phase-shift commands for multiple PLLs. It sits between the UART RX core and the PLL phase-step sequencer. Relative to the current mapper it adds:

- generic PLL/counter count and count width;
- a valid/ready command handshake with back-pressure;
- frame error detection and resynchronisation;
- an inter-byte timeout.

## Interface

Parameters:
- NUM_PLLS, 2: PLLs addressed; PLL_W = max(1, clog2(NUM_PLLS)).
- CHANS_PER_PLL, 4: counters per PLL, power of two.
- CNT_SEL_W, 3: width of the phasecounterselect field.
- COUNTER_OFFSET, 2: added to the local channel index to form the counter select.
- COUNT_W, 8: width of the period count.
- TIMEOUT_CYCLES, 0: inter-byte timeout in clocks; 0 disables it.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte; valid while i_rx_ready is high.
- i_rx_ready  in  1  level strobe from the RX core; its rising edge delivers one byte.
- i_cmd_ready  in  1  sequencer accepts the command.
- o_cmd_valid  out  1  command available.
- o_cmd_pll  out  PLL_W  target PLL.
- o_cmd_counter  out  CNT_SEL_W  phasecounterselect value.
- o_cmd_updown  out  1  phase direction.
- o_cmd_periods  out  COUNT_W  number of phase steps (≥1).
- o_err  out  1  one-cycle error pulse.
- o_err_code  out  3  error code; holds its value until the next error.
- o_busy  out  1  high whenever the parser is not in IDLE.

## Operation

Frame format: CH, DIR, D1..Dn, 'S' (0x53).
- CH = '0'+c, where c < NUM_PLLS*CHANS_PER_PLL.
- DIR = '0' or '1'.
- D = ASCII '0'..'9', n ≥ 1.

Field mapping:
- pll = c / CHANS_PER_PLL.
- counter = (c % CHANS_PER_PLL) + COUNTER_OFFSET, truncated to CNT_SEL_W.
- updown = DIR − '0'.
- Accumulation: acc = acc*10 + (D − '0'), computed in COUNT_W+4 bits.

Byte event: i_rx_ready high while its registered previous value is low. At most one byte is consumed per event.

States:
- IDLE:
  - 'S' is ignored silently (resync).
  - A valid CH latches pll/counter and goes to DIR.
  - Anything else raises BAD_CHAN and goes to DRAIN.
- DIR:
  - '0'/'1' latches updown, clears acc and goes to DIGITS.
  - 'S' raises EMPTY and goes to IDLE.
  - Anything else raises BAD_DIR and goes to DRAIN.
- DIGITS:
  - A digit updates acc; if the new acc exceeds 2^COUNT_W−1, raise OVERFLOW and go to DRAIN.
  - 'S' with at least one digit and acc ≠ 0 loads the o_cmd_* registers and goes to HOLD.
  - 'S' with no digits or acc = 0 raises EMPTY and goes to IDLE.
  - Any other byte raises BAD_DIGIT and goes to DRAIN.
- DRAIN: discards every byte; 'S' goes to IDLE. No further error pulses are raised.
- HOLD:
  - o_cmd_valid is high; outputs are stable.
  - i_cmd_ready high transfers the command and goes to IDLE.
  - A byte event raises OVERRUN, the byte is dropped, and the state stays HOLD.

Error codes: 1 BAD_CHAN, 2 BAD_DIR, 3 BAD_DIGIT, 4 OVERFLOW, 5 EMPTY, 6 OVERRUN, 7 TIMEOUT.

Timeout: the counter clears on every byte event and counts only in DIR, DIGITS and DRAIN. When it reaches TIMEOUT_CYCLES, raise TIMEOUT and go to IDLE. It never fires in HOLD.

## Timing

- Reset: state IDLE; all outputs 0; the previous-ready register is 0. Reset overrides everything, including HOLD and mid-frame, and the partial frame is lost.
- o_cmd_valid rises on the clock after the cycle in which the 'S' event is detected.
- Transfer happens on the edge where o_cmd_valid and i_cmd_ready are both high. o_cmd_valid is low on the following cycle.
- Back-to-back commands: the earliest next CH byte is accepted in the cycle after the transfer. The minimum frame spacing is set by the RX core, not by the parser.
- o_err is high for exactly one cycle, registered, on the cycle after the offending event. o_err_code updates in the same cycle.
- i_rx_ready held high for many cycles counts as one byte. Each byte needs a low-to-high transition.
- The o_cmd_* fields stay unchanged outside the load cycle, including after a transfer.

## Structure

- Package uart_phase_cmd_pkg holds:
  - ASCII constants ('0', '9', 'S');
  - the error code enum;
  - the state enum (IDLE, DIR, DIGITS, DRAIN, HOLD).
- Sub-module uart_dec_accum handles the digit check, the ×10+d step, overflow detection and the digit-seen flag. It has COUNT_W as a parameter and a clear input.
- Timeout counter and edge detector are inline.

## Test plan

Defaults unless stated.
- "5","1","1","2","S" → one o_cmd_valid with pll=1, counter=3, updown=1, periods=12, 1 cycle after the 'S' event; no o_err.
- "3","0","2","5","5","S" → pll=0, counter=5, periods=255. Then "3","0","2","5","6" → OVERFLOW (4) at '6'; the following 'S' returns to IDLE with no command and no second error.
- "9" → BAD_CHAN (1). "1","x" → BAD_DIR (2). "1","0","0","S" → EMPTY (5), no command.
- Hold i_cmd_ready low for 20 cycles after "0","0","7","S". A byte '4' arriving in HOLD raises OVERRUN (6) and leaves periods=7 unchanged. Raising i_cmd_ready gives a single transfer, then IDLE.
- TIMEOUT_CYCLES=50, send "2","1", then go idle → TIMEOUT (7) exactly 50 cycles after the '1' event. The next frame "2","1","3","S" parses normally.
- Assert i_rst in DIGITS after "6","0","4" → all outputs 0. Send "S" then "6","0","4","S" → periods=4, pll=1, counter=4.

Source files
------------

// File: rtl/uart_phase_cmd_pkg.sv
// Shared constants, error codes and parser states for the UART phase-shift command parser.
package uart_phase_cmd_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_S    = 8'h53;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BAD_CHAN  = 3'd1,
        ERR_BAD_DIR   = 3'd2,
        ERR_BAD_DIGIT = 3'd3,
        ERR_OVERFLOW  = 3'd4,
        ERR_EMPTY     = 3'd5,
        ERR_OVERRUN   = 3'd6,
        ERR_TIMEOUT   = 3'd7
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIR    = 3'd1,
        ST_DIGITS = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_phase_cmd_parser_if.sv
// Byte-input and command-output bundle of the phase command parser.
interface uart_phase_cmd_parser_if #(
    parameter int PLL_W     = 1,
    parameter int CNT_SEL_W = 3,
    parameter int COUNT_W   = 8
);
    logic [7:0]           i_rx_data;
    logic                 i_rx_ready;
    logic                 i_cmd_ready;
    logic                 o_cmd_valid;
    logic [PLL_W-1:0]     o_cmd_pll;
    logic [CNT_SEL_W-1:0] o_cmd_counter;
    logic                 o_cmd_updown;
    logic [COUNT_W-1:0]   o_cmd_periods;
    logic                 o_err;
    logic [2:0]           o_err_code;
    logic                 o_busy;

    modport master (
        output i_rx_data, i_rx_ready, i_cmd_ready,
        input  o_cmd_valid, o_cmd_pll, o_cmd_counter, o_cmd_updown, o_cmd_periods,
        input  o_err, o_err_code, o_busy
    );

    modport slave (
        input  i_rx_data, i_rx_ready, i_cmd_ready,
        output o_cmd_valid, o_cmd_pll, o_cmd_counter, o_cmd_updown, o_cmd_periods,
        output o_err, o_err_code, o_busy
    );
endinterface

// File: rtl/uart_dec_accum.sv
// Decimal accumulator: digit check, acc*10+d step with overflow detection, digit-seen flag.
module uart_dec_accum
    import uart_phase_cmd_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    input  logic [7:0]         data,
    output logic               digit,
    output logic               overflow,
    output logic [COUNT_W-1:0] acc,
    output logic               seen
);
    // Four guard bits hold acc*10+9 for any acc that still fits COUNT_W bits.
    localparam int WIDE_W = COUNT_W + 4;

    logic [7:0]        digit_val_s;
    logic [WIDE_W-1:0] next_s;

    assign digit       = is_ascii_digit(data);
    assign digit_val_s = data - ASCII_ZERO;
    assign next_s      = ({4'd0, acc} * WIDE_W'(4'd10)) + WIDE_W'(digit_val_s);
    assign overflow    = |next_s[WIDE_W-1:COUNT_W];

    // Accumulator and digit-seen register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= {COUNT_W{1'b0}};
            seen <= 1'b0;
        end else if (clear) begin
            acc  <= {COUNT_W{1'b0}};
            seen <= 1'b0;
        end else if (step && digit) begin
            acc  <= next_s[COUNT_W-1:0];
            seen <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_phase_cmd_parser.sv
// Parses "CH DIR D..D S" ASCII frames from the UART receiver into phase-step commands
// with valid/ready hand-off, error reporting, resync on 'S' and an optional inter-byte timeout.
module uart_phase_cmd_parser
    import uart_phase_cmd_pkg::*;
#(
    parameter int NUM_PLLS       = 2,
    parameter int CHANS_PER_PLL  = 4,
    parameter int CNT_SEL_W      = 3,
    parameter int COUNTER_OFFSET = 2,
    parameter int COUNT_W        = 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    uart_phase_cmd_parser_if.slave  bus
);
    localparam int PLL_W  = (NUM_PLLS > 1) ? $clog2(NUM_PLLS) : 1;
    localparam int NUM_CH = NUM_PLLS * CHANS_PER_PLL;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t               state_r;
    logic                 rx_prev_r;
    logic [TMO_W-1:0]     tmo_cnt_r;
    logic [PLL_W-1:0]     pll_lat_r;
    logic [CNT_SEL_W-1:0] cnt_lat_r;
    logic                 updown_lat_r;

    logic                 byte_ev_s;
    logic                 is_s_s;
    logic [7:0]           chan_s;
    logic                 chan_ok_s;
    logic [PLL_W-1:0]     ch_pll_s;
    logic [CNT_SEL_W-1:0] ch_cnt_s;
    logic                 dir_ok_s;
    logic                 counting_s;
    logic                 tmo_fire_s;
    logic                 acc_clear_s;
    logic                 acc_step_s;
    logic                 acc_digit_s;
    logic                 acc_ovf_s;
    logic [COUNT_W-1:0]   acc_val_s;
    logic                 acc_seen_s;

    assign byte_ev_s  = bus.i_rx_ready && !rx_prev_r;
    assign is_s_s     = (bus.i_rx_data == ASCII_S);
    assign chan_s     = bus.i_rx_data - ASCII_ZERO;
    assign chan_ok_s  = (bus.i_rx_data >= ASCII_ZERO) && (32'(chan_s) < 32'(NUM_CH));
    assign ch_pll_s   = PLL_W'(32'(chan_s) / 32'(CHANS_PER_PLL));
    assign ch_cnt_s   = CNT_SEL_W'((32'(chan_s) % 32'(CHANS_PER_PLL)) + 32'(COUNTER_OFFSET));
    assign dir_ok_s   = (bus.i_rx_data == ASCII_ZERO) || (bus.i_rx_data == ASCII_ONE);

    // The timeout only runs while a frame is partially received; HOLD waits on the sequencer.
    assign counting_s = (state_r == ST_DIR) || (state_r == ST_DIGITS) || (state_r == ST_DRAIN);
    assign tmo_fire_s = (TIMEOUT_CYCLES != 0) && counting_s && (tmo_cnt_r == TMO_LAST) && !byte_ev_s;

    assign acc_clear_s = (state_r == ST_DIR) && byte_ev_s && dir_ok_s;
    assign acc_step_s  = (state_r == ST_DIGITS) && byte_ev_s;
    assign bus.o_busy  = (state_r != ST_IDLE);

    uart_dec_accum #(
        .COUNT_W (COUNT_W)
    ) u_accum (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (acc_clear_s),
        .step     (acc_step_s),
        .data     (bus.i_rx_data),
        .digit    (acc_digit_s),
        .overflow (acc_ovf_s),
        .acc      (acc_val_s),
        .seen     (acc_seen_s)
    );

    // Frame FSM with edge detector, timeout counter and registered command/error outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r           <= ST_IDLE;
            rx_prev_r         <= 1'b0;
            tmo_cnt_r         <= {TMO_W{1'b0}};
            pll_lat_r         <= {PLL_W{1'b0}};
            cnt_lat_r         <= {CNT_SEL_W{1'b0}};
            updown_lat_r      <= 1'b0;
            bus.o_cmd_valid   <= 1'b0;
            bus.o_cmd_pll     <= {PLL_W{1'b0}};
            bus.o_cmd_counter <= {CNT_SEL_W{1'b0}};
            bus.o_cmd_updown  <= 1'b0;
            bus.o_cmd_periods <= {COUNT_W{1'b0}};
            bus.o_err         <= 1'b0;
            bus.o_err_code    <= ERR_NONE;
        end else begin
            rx_prev_r <= bus.i_rx_ready;
            bus.o_err <= 1'b0;

            if (byte_ev_s) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if (counting_s && (tmo_cnt_r != TMO_LAST)) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (byte_ev_s && !is_s_s) begin
                        if (chan_ok_s) begin
                            pll_lat_r <= ch_pll_s;
                            cnt_lat_r <= ch_cnt_s;
                            state_r   <= ST_DIR;
                        end else begin
                            bus.o_err      <= 1'b1;
                            bus.o_err_code <= ERR_BAD_CHAN;
                            state_r        <= ST_DRAIN;
                        end
                    end
                end
                ST_DIR: begin
                    if (byte_ev_s) begin
                        if (dir_ok_s) begin
                            updown_lat_r <= bus.i_rx_data[0];
                            state_r      <= ST_DIGITS;
                        end else if (is_s_s) begin
                            bus.o_err      <= 1'b1;
                            bus.o_err_code <= ERR_EMPTY;
                            state_r        <= ST_IDLE;
                        end else begin
                            bus.o_err      <= 1'b1;
                            bus.o_err_code <= ERR_BAD_DIR;
                            state_r        <= ST_DRAIN;
                        end
                    end else if (tmo_fire_s) begin
                        bus.o_err      <= 1'b1;
                        bus.o_err_code <= ERR_TIMEOUT;
                        state_r        <= ST_IDLE;
                    end
                end
                ST_DIGITS: begin
                    if (byte_ev_s) begin
                        if (acc_digit_s) begin
                            if (acc_ovf_s) begin
                                bus.o_err      <= 1'b1;
                                bus.o_err_code <= ERR_OVERFLOW;
                                state_r        <= ST_DRAIN;
                            end
                        end else if (is_s_s) begin
                            if (acc_seen_s && (acc_val_s != {COUNT_W{1'b0}})) begin
                                bus.o_cmd_valid   <= 1'b1;
                                bus.o_cmd_pll     <= pll_lat_r;
                                bus.o_cmd_counter <= cnt_lat_r;
                                bus.o_cmd_updown  <= updown_lat_r;
                                bus.o_cmd_periods <= acc_val_s;
                                state_r           <= ST_HOLD;
                            end else begin
                                bus.o_err      <= 1'b1;
                                bus.o_err_code <= ERR_EMPTY;
                                state_r        <= ST_IDLE;
                            end
                        end else begin
                            bus.o_err      <= 1'b1;
                            bus.o_err_code <= ERR_BAD_DIGIT;
                            state_r        <= ST_DRAIN;
                        end
                    end else if (tmo_fire_s) begin
                        bus.o_err      <= 1'b1;
                        bus.o_err_code <= ERR_TIMEOUT;
                        state_r        <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (byte_ev_s && is_s_s) begin
                        state_r <= ST_IDLE;
                    end else if (tmo_fire_s) begin
                        bus.o_err      <= 1'b1;
                        bus.o_err_code <= ERR_TIMEOUT;
                        state_r        <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (byte_ev_s) begin
                        bus.o_err      <= 1'b1;
                        bus.o_err_code <= ERR_OVERRUN;
                    end
                    if (bus.i_cmd_ready) begin
                        bus.o_cmd_valid <= 1'b0;
                        state_r         <= ST_IDLE;
                    end
                end
                default: begin
                    bus.o_cmd_valid <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_phase_cmd_parser.sv
// Directed bench for uart_phase_cmd_parser: scoreboard queues of expected commands and errors.
module tb_uart_phase_cmd_parser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_phase_cmd_parser_if #(.PLL_W(1), .CNT_SEL_W(3), .COUNT_W(8)) bus ();

    uart_phase_cmd_parser #(
        .NUM_PLLS       (2),
        .CHANS_PER_PLL  (4),
        .CNT_SEL_W      (3),
        .COUNTER_OFFSET (2),
        .COUNT_W        (8),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        int pll;
        int counter;
        int updown;
        int periods;
    } cmd_t;

    cmd_t cmd_q[$];
    int   err_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic cmd_t model_cmd(input int c, input int dir, input int periods);
        cmd_t r;
        r.pll     = c / 4;
        r.counter = ((c % 4) + 2) % 8;
        r.updown  = dir;
        r.periods = periods;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One byte: ready rises once and stays high for 'hold' clock edges.
    task automatic send(input logic [7:0] b, input int hold = 1);
        bus.i_rx_data  = b;
        bus.i_rx_ready = 1'b1;
        tick(hold);
        bus.i_rx_ready = 1'b0;
    endtask

    task automatic put(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            tick(2);
        end
    endtask

    task automatic transfer();
        check("valid_before_xfer", bus.o_cmd_valid, 1);
        bus.i_cmd_ready = 1'b1;
        tick(1);
        bus.i_cmd_ready = 1'b0;
        check("valid_after_xfer", bus.o_cmd_valid, 0);
        check("busy_after_xfer", bus.o_busy, 0);
        tick(3);
        check("single_xfer", bus.o_cmd_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, bus.o_cmd_valid, 0);
        check({tag, "_pll"}, bus.o_cmd_pll, 0);
        check({tag, "_counter"}, bus.o_cmd_counter, 0);
        check({tag, "_updown"}, bus.o_cmd_updown, 0);
        check({tag, "_periods"}, bus.o_cmd_periods, 0);
        check({tag, "_err"}, bus.o_err, 0);
        check({tag, "_err_code"}, bus.o_err_code, 0);
        check({tag, "_busy"}, bus.o_busy, 0);
    endtask

    // Scoreboard: every error pulse and every rise of o_cmd_valid must match the queues.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.o_err === 1'b1) begin
                check("err_expected", {31'd0, err_q.size() > 0}, 1);
                if (err_q.size() > 0) check("err_code", bus.o_err_code, err_q.pop_front());
            end
            if (bus.o_cmd_valid === 1'b1 && prev_valid === 1'b0) begin
                check("cmd_expected", {31'd0, cmd_q.size() > 0}, 1);
                if (cmd_q.size() > 0) begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    check("cmd_pll", bus.o_cmd_pll, e.pll);
                    check("cmd_counter", bus.o_cmd_counter, e.counter);
                    check("cmd_updown", bus.o_cmd_updown, e.updown);
                    check("cmd_periods", bus.o_cmd_periods, e.periods);
                end
            end
            prev_valid = bus.o_cmd_valid;
        end
    end

    initial begin
        int n;
        bus.i_rx_data   = 8'h00;
        bus.i_rx_ready  = 1'b0;
        bus.i_cmd_ready = 1'b0;
        rst = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // "5112S" with the channel byte held high for several cycles.
        cmd_q.push_back(model_cmd(5, 1, 12));
        send("5", 6);
        tick(2);
        put("112");
        check("no_early_valid", bus.o_cmd_valid, 0);
        send("S");
        check("valid_one_cycle_after_s", bus.o_cmd_valid, 1);
        check("busy_in_hold", bus.o_busy, 1);
        transfer();

        // Largest count, then one past it.
        cmd_q.push_back(model_cmd(3, 0, 255));
        put("30255");
        send("S");
        transfer();
        put("3025");
        err_q.push_back(4);
        send("6");
        check("overflow_pulse", bus.o_err, 1);
        tick(1);
        check("err_one_cycle", bus.o_err, 0);
        tick(1);
        put("S");
        check("idle_after_drain", bus.o_busy, 0);
        check("no_cmd_after_overflow", bus.o_cmd_valid, 0);

        // Bad channel, bad direction, zero count.
        err_q.push_back(1);
        send("9");
        check("bad_chan_pulse", bus.o_err, 1);
        tick(2);
        put("S");
        put("1");
        err_q.push_back(2);
        send("x");
        check("bad_dir_pulse", bus.o_err, 1);
        tick(2);
        put("S");
        put("100");
        err_q.push_back(5);
        send("S");
        check("empty_pulse", bus.o_err, 1);
        check("idle_after_empty", bus.o_busy, 0);
        tick(4);
        check("err_code_holds", bus.o_err_code, 5);
        check("no_cmd_after_empty", bus.o_cmd_valid, 0);

        // Back-pressure and overrun while holding a command.
        cmd_q.push_back(model_cmd(0, 0, 7));
        put("007");
        send("S");
        tick(20);
        check("valid_held", bus.o_cmd_valid, 1);
        err_q.push_back(6);
        send("4");
        check("overrun_pulse", bus.o_err, 1);
        tick(2);
        check("periods_kept", bus.o_cmd_periods, 7);
        check("still_busy", bus.o_busy, 1);
        transfer();

        // Inter-byte timeout measured from the '1' event edge.
        put("2");
        err_q.push_back(7);
        send("1");
        n = 0;
        while (bus.o_err !== 1'b1 && n < 80) begin
            tick(1);
            n++;
        end
        check("timeout_latency", n, 50);
        tick(1);
        check("idle_after_timeout", bus.o_busy, 0);
        cmd_q.push_back(model_cmd(2, 1, 3));
        put("213");
        send("S");
        transfer();

        // Reset in the middle of a frame.
        put("604");
        rst = 1'b1;
        tick(2);
        check_all_zero("midframe_reset");
        rst = 1'b0;
        tick(1);
        put("S");
        cmd_q.push_back(model_cmd(6, 0, 4));
        put("604");
        send("S");
        transfer();

        tick(5);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
